// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit processor. Moore-style outputs per state, with the
// memory-facing strobes qualified by mem_ready, a memory wait/timeout counter, an illegal-opcode
// trap and a retired-instruction counter.
module mc_control_fsm #(
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned FUNCT_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [2:0]         opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IoD,
    output logic               MemR,
    output logic               MemW,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               branch,
    output logic [1:0]         Mem2Reg,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               PCSrc,
    output logic [1:0]         branchType,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   retired,
    output logic [3:0]         state_dbg
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StRExec   = 4'd2,
        StRiExec  = 4'd3,
        StAluWb   = 4'd4,
        StMemAddr = 4'd5,
        StLwMem   = 4'd6,
        StLwWb    = 4'd7,
        StSwMem   = 4'd8,
        StBranch  = 4'd9,
        StJal     = 4'd10,
        StJalr    = 4'd11,
        StTrap    = 4'd15
    } state_e;

    // Counter only has to reach MEM_TIMEOUT-1 before the trap fires.
    localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    localparam logic [ALUOP_W-1:0] AluAdd  = '0;
    localparam logic [ALUOP_W-1:0] AluSub  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluIdle = '1;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q;
    logic             in_wait, timeout, retire;

    // Next-state, trap cause and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        in_wait = (state_q == StFetch) || (state_q == StLwMem) || (state_q == StSwMem);
        timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (wait_q == WaitLast);
        case (state_q)
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    3'd0:       state_d = StRExec;
                    3'd1:       state_d = StRiExec;
                    3'd2, 3'd3: state_d = StMemAddr;
                    3'd4:       state_d = StBranch;
                    3'd5:       state_d = StJal;
                    3'd6:       state_d = StJalr;
                    default: begin
                        state_d = StTrap;
                        cause_d = 2'd1;
                    end
                endcase
            end
            StRExec, StRiExec: state_d = StAluWb;
            StMemAddr: state_d = (opcode == 3'd2) ? StLwMem : StSwMem;
            StLwMem:   if (mem_ready) state_d = StLwWb;
            StSwMem:   if (mem_ready) state_d = StFetch;
            StAluWb, StLwWb, StBranch, StJal, StJalr: state_d = StFetch;
            StTrap:    state_d = StTrap;
            default:   state_d = StFetch;
        endcase
        if (timeout) begin
            state_d = StTrap;
            cause_d = 2'd2;
        end
        // Cleared on entry to a waiting state, counts not-ready cycles while staying.
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_wait && !mem_ready) begin
            wait_d = wait_q + WaitW'(1);
        end
        retire = (state_d == StFetch) &&
                 ((state_q == StAluWb) || (state_q == StLwWb) || (state_q == StSwMem) ||
                  (state_q == StBranch) || (state_q == StJal) || (state_q == StJalr));
    end

    // State, counters and trap cause; synchronous reset takes priority.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            cause_q   <= 2'd0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Per-state datapath controls; forced to defaults while Reset is high.
    always_comb begin
        PCWrite    = 1'b0;
        IoD        = 1'b0;
        MemR       = 1'b0;
        MemW       = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        branch     = 1'b0;
        Mem2Reg    = 2'd0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ALUOp      = AluIdle;
        PCSrc      = 1'b0;
        branchType = 2'd0;
        trap       = 1'b0;
        if (!Reset) begin
            case (state_q)
                StFetch: begin
                    MemR    = 1'b1;
                    ALUSrcB = 2'd1;
                    ALUOp   = AluAdd;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                StDecode: begin
                    ALUSrcA = 2'd2;
                    ALUSrcB = 2'd2;
                    ALUOp   = AluAdd;
                end
                StRExec: begin
                    ALUSrcA = 2'd1;
                    ALUOp   = funct[ALUOP_W-1:0];
                end
                StRiExec: begin
                    ALUSrcA = 2'd1;
                    ALUSrcB = 2'd2;
                    ALUOp   = funct[ALUOP_W-1:0];
                end
                StAluWb:  RegWrite = 1'b1;
                StMemAddr: begin
                    ALUSrcA = 2'd1;
                    ALUSrcB = 2'd2;
                    ALUOp   = AluAdd;
                end
                StLwMem: begin
                    MemR = 1'b1;
                    IoD  = 1'b1;
                end
                StLwWb: begin
                    RegWrite = 1'b1;
                    Mem2Reg  = 2'd1;
                end
                StSwMem: begin
                    MemW = 1'b1;
                    IoD  = 1'b1;
                end
                StBranch: begin
                    ALUSrcA    = 2'd1;
                    ALUOp      = AluSub;
                    branch     = 1'b1;
                    PCSrc      = 1'b1;
                    branchType = funct[1:0];
                end
                StJal: begin
                    RegWrite = 1'b1;
                    Mem2Reg  = 2'd2;
                    PCWrite  = 1'b1;
                    PCSrc    = 1'b1;
                end
                StJalr: begin
                    ALUSrcA  = 2'd1;
                    ALUSrcB  = 2'd2;
                    ALUOp    = AluAdd;
                    RegWrite = 1'b1;
                    Mem2Reg  = 2'd2;
                    PCWrite  = 1'b1;
                end
                StTrap:   trap = 1'b1;
                default:  trap = 1'b0;
            endcase
        end
    end

    assign trap_cause = cause_q;
    assign retired    = retired_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multi-cycle control unit for the 16-bit processor. A Moore FSM, with a small set of strobes qualified by mem_ready, sequences each instruction through fetch, decode, execute, memory and writeback. Over the first-generation controller it adds variable-latency memory handshaking, a memory timeout, an illegal-opcode trap, a retired-instruction counter and a state debug port. It drives the datapath muxes, ALU, register file and memory enables.

Parameters:
ALUOP_W, 3, ALU operation code width; must be <= FUNCT_W.
FUNCT_W, 4, instruction funct field width.
MEM_TIMEOUT, 16, consecutive not-ready cycles before a timeout trap; 0 disables the timeout.
CNT_W, 16, retired-instruction counter width.

Ports:
CLK  in  1  clock; all state changes on rising edge.
Reset  in  1  synchronous, active-high reset.
opcode  in  3  instruction opcode from the IR.
funct  in  FUNCT_W  instruction funct field from the IR.
mem_ready  in  1  memory has completed the current read or write this cycle.
PCWrite, IoD, MemR, MemW, IRWrite, RegWrite, branch  out  1 each  datapath enables.
Mem2Reg  out  2  register write source: 0 ALUOut, 1 MDR, 2 PC.
ALUSrcA  out  2  ALU A source: 0 PC, 1 regA, 2 oldPC.
ALUSrcB  out  2  ALU B source: 0 regB, 1 const 2, 2 imm.
ALUOp  out  ALUOP_W  ALU operation: 0 add, 1 sub, all-ones idle.
PCSrc  out  1  PC source: 0 ALU result, 1 ALUOut.
branchType  out  2  branch condition select, equal to funct[1:0].
trap  out  1  FSM is halted in TRAP.
trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout.
retired  out  CNT_W  count of completed instructions.
state_dbg  out  4  current state encoding.

Behaviour:
- Reset and clocking:
  - Clock is CLK; reset is synchronous, active-high.
  - Reset has priority over every other event. The edge with Reset high forces state FETCH, retired 0, trap_cause 0 and the wait counter 0.
  - While Reset is high, all outputs are combinationally forced to their defaults, including mid-wait: MemR and MemW drop in the same cycle.
- Output defaults:
  - All 1-bit outputs 0.
  - Mux selects 0.
  - ALUOp all-ones.
  - branchType 0.
- State encodings: FETCH 0, DECODE 1, R_EXEC 2, RI_EXEC 3, ALU_WB 4, MEM_ADDR 5, LW_MEM 6, LW_WB 7, SW_MEM 8, BRANCH 9, JAL 10, JALR 11, TRAP 15.
- Per-state outputs (anything not listed takes its default):
  - FETCH: MemR=1, IoD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSrc=0; IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=2, ALUSrcB=2, ALUOp=add. This precomputes the branch/JAL target into ALUOut.
  - R_EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=funct[ALUOP_W-1:0].
  - RI_EXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=funct[ALUOP_W-1:0].
  - ALU_WB: RegWrite=1, Mem2Reg=0.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=add.
  - LW_MEM: MemR=1, IoD=1.
  - LW_WB: RegWrite=1, Mem2Reg=1.
  - SW_MEM: MemW=1, IoD=1. MemW is held until mem_ready.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=sub, branch=1, PCSrc=1, branchType=funct[1:0]. The datapath gates the PC write on the branch condition.
  - JAL: RegWrite=1, Mem2Reg=2, PCWrite=1, PCSrc=1.
  - JALR: ALUSrcA=1, ALUSrcB=2, ALUOp=add, RegWrite=1, Mem2Reg=2, PCWrite=1, PCSrc=0.
  - TRAP: all outputs at defaults; trap=1.
- Transitions:
  - FETCH -> DECODE when mem_ready=1; otherwise stay.
  - DECODE, by opcode: 0->R_EXEC, 1->RI_EXEC, 2 or 3->MEM_ADDR, 4->BRANCH, 5->JAL, 6->JALR, 7->TRAP with trap_cause=1.
  - R_EXEC and RI_EXEC -> ALU_WB.
  - MEM_ADDR -> LW_MEM if opcode=2, SW_MEM if opcode=3. Opcode is sampled again here; the IR is stable.
  - LW_MEM -> LW_WB on mem_ready.
  - SW_MEM -> FETCH on mem_ready.
  - ALU_WB, LW_WB, BRANCH, JAL and JALR -> FETCH.
  - TRAP is terminal until Reset.
- Memory wait counter:
  - Cleared on entry to FETCH, LW_MEM or SW_MEM.
  - Increments each cycle in those states while mem_ready=0.
  - If MEM_TIMEOUT>0, mem_ready=0 and the counter equals MEM_TIMEOUT-1, the next state is TRAP with trap_cause=2.
  - mem_ready=1 in that same cycle wins and completes normally.
- Latency with mem_ready tied high (cycles from FETCH entry to FETCH re-entry):
  - R/RI: 4.
  - LW: 5.
  - SW: 4.
  - BRANCH, JAL, JALR: 3.
  - Each wait cycle adds 1.
- retired counter:
  - Increments by 1 on every transition into FETCH from ALU_WB, LW_WB, SW_MEM, BRANCH, JAL or JALR.
  - Never increments on entry to TRAP.
  - Wraps modulo 2^CNT_W.
- trap_cause holds its value until Reset.
- state_dbg = current state.

Test Plan:
- Reset high 2 cycles, then low with mem_ready=1, opcode=0, funct=4'b0010 -> states 0,1,2,4,0; ALUOp=3'b010 in R_EXEC; RegWrite=1 only in ALU_WB; retired=1.
- LW (opcode=2) with mem_ready low 3 cycles in LW_MEM -> MemR=IoD=1 held 4 cycles; LW_WB has Mem2Reg=1; total 8 cycles; retired increments once.
- SW (opcode=3) with mem_ready stuck 0, MEM_TIMEOUT=16 -> exactly 16 cycles in SW_MEM, then TRAP, trap=1, trap_cause=2, retired unchanged; Reset clears trap and returns to FETCH.
- opcode=7 in DECODE -> TRAP on next edge, trap_cause=1, all strobes 0 afterwards.
- BRANCH with funct=4'b0011, then JAL, then JALR -> branchType=2'b11, ALUOp=1, PCSrc=1 in BRANCH; JAL has Mem2Reg=2 and PCSrc=1; JALR has PCSrc=0 and ALUSrcB=2; retired=3 after the sequence.
- Reset asserted in the second wait cycle of FETCH -> MemR drops the same cycle; the next state is FETCH with retired=0; with CNT_W=2, 5 R-type instructions leave retired=1.
